regfile_stack: RTL and testbench

//  Parametrised CPU register file plus stack-pointer unit for the 65C02-family cores.
//  - Register file: NREGS x DW, two combinational read ports (src, idx), one write port.
//  - Stack pointer: SW bits, multi-byte push/pull adjust, sticky wrap flags.
//  - Sits beside the ALU; the control FSM drives the select/strobe inputs.

---
 rtl/regfile_stack.sv | 85 ++++++++
 tb/tb_regfile_stack.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_stack.sv
// Register file with two combinational read ports and a stack-pointer unit
// for the 65C02-family cores; the control FSM drives every select and strobe.
module regfile_stack #(
    parameter int          DW       = 8,
    parameter int          NREGS    = 4,
    parameter int          SW       = 8,
    parameter logic [31:0] SP_RESET = 32'hFF,
    parameter bit          BYPASS   = 1'b0,
    localparam int         AW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reg_we,
    input  logic [AW-1:0] reg_dst,
    input  logic [DW-1:0] dst,
    input  logic [AW-1:0] reg_src,
    input  logic [AW-1:0] reg_idx,
    output logic [DW-1:0] src,
    output logic [DW-1:0] idx,
    output logic [SW-1:0] S,
    input  logic          txs,
    input  logic          push,
    input  logic          pull,
    input  logic [1:0]    sp_cnt,
    output logic          sp_unf,
    output logic          sp_ovf,
    input  logic          sp_clr
);

    logic [DW-1:0] regs [NREGS];
    logic [SW:0]   cnt_w;
    logic [SW:0]   dec;
    logic [SW:0]   inc;
    logic          unf_set;
    logic          ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[reg_dst] <= dst;
        end
    end

    always_comb begin
        src = regs[reg_src];
        idx = regs[reg_idx];
        if (BYPASS && reg_we) begin
            if (reg_src == reg_dst) begin
                src = dst;
            end
            if (reg_idx == reg_dst) begin
                idx = dst;
            end
        end
    end

    // One extra bit on the adjust arithmetic carries the wrap indication.
    assign cnt_w   = (SW+1)'(sp_cnt);
    assign dec     = {1'b0, S} - cnt_w;
    assign inc     = {1'b0, S} + cnt_w;
    assign unf_set = push && !txs && dec[SW];
    assign ovf_set = pull && !txs && !push && inc[SW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S      <= SP_RESET[SW-1:0];
            sp_unf <= 1'b0;
            sp_ovf <= 1'b0;
        end else begin
            if (txs) begin
                S <= src[SW-1:0];
            end else if (push) begin
                S <= dec[SW-1:0];
            end else if (pull) begin
                S <= inc[SW-1:0];
            end
            sp_unf <= unf_set | (sp_unf & ~sp_clr);
            sp_ovf <= ovf_set | (sp_ovf & ~sp_clr);
        end
    end

endmodule

// File: tb/tb_regfile_stack.sv
// Drives a default-sized instance and a wide bypassing instance with shared stimulus;
// a scoreboard queue feeds a monitor that compares both against integer models.
module tb_regfile_stack;

    typedef struct packed {
        logic        we;
        logic [2:0]  dst_sel;
        logic [15:0] dst;
        logic [2:0]  src_sel;
        logic [2:0]  idx_sel;
        logic        txs;
        logic        push;
        logic        pull;
        logic [1:0]  cnt;
        logic        clr;
    } stim_t;

    typedef struct packed {
        logic [7:0][15:0] regs;
        logic [15:0]      s;
        logic             unf;
        logic             ovf;
    } model_t;

    typedef struct packed {
        logic [15:0] a_src_pre, a_idx_pre, b_src_pre, b_idx_pre;
        logic [15:0] a_src, a_idx, b_src, b_idx, a_s, b_s;
        logic        a_unf, a_ovf, b_unf, b_ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        reg_we;
    logic [2:0]  reg_dst;
    logic [15:0] dst;
    logic [2:0]  reg_src;
    logic [2:0]  reg_idx;
    logic        txs, push, pull, sp_clr;
    logic [1:0]  sp_cnt;

    logic [7:0]  src_a, idx_a, s_a;
    logic        unf_a, ovf_a;
    logic [15:0] src_b, idx_b;
    logic [8:0]  s_b;
    logic        unf_b, ovf_b;

    int     tests = 0;
    int     failures = 0;
    exp_t   sb[$];
    model_t mod_a, mod_b;

    regfile_stack dut_a (
        .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_dst(reg_dst[1:0]), .dst(dst[7:0]),
        .reg_src(reg_src[1:0]), .reg_idx(reg_idx[1:0]), .src(src_a), .idx(idx_a), .S(s_a),
        .txs(txs), .push(push), .pull(pull), .sp_cnt(sp_cnt), .sp_unf(unf_a), .sp_ovf(ovf_a),
        .sp_clr(sp_clr)
    );

    regfile_stack #(.DW(16), .NREGS(8), .SW(9), .SP_RESET(32'h1FF), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_dst(reg_dst), .dst(dst),
        .reg_src(reg_src), .reg_idx(reg_idx), .src(src_b), .idx(idx_b), .S(s_b),
        .txs(txs), .push(push), .pull(pull), .sp_cnt(sp_cnt), .sp_unf(unf_b), .sp_ovf(ovf_b),
        .sp_clr(sp_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_read(model_t m, int sel, stim_t st, bit byp,
                                               int nregs, int dw);
        int mask = (1 << dw) - 1;
        if (byp && st.we && sel == int'(st.dst_sel) % nregs) begin
            return st.dst & 16'(mask);
        end
        return m.regs[sel];
    endfunction

    function automatic model_t model_step(model_t m, stim_t st, bit byp, int nregs,
                                          int dw, int sw);
        model_t n = m;
        int span = 1 << sw;
        int mask = (1 << dw) - 1;
        int cur = int'(m.s);
        int nxt = cur;
        bit us = 1'b0;
        bit os = 1'b0;
        int srcv = int'(model_read(m, int'(st.src_sel) % nregs, st, byp, nregs, dw));
        if (st.we) begin
            n.regs[int'(st.dst_sel) % nregs] = st.dst & 16'(mask);
        end
        if (st.txs) begin
            nxt = srcv % span;
        end else if (st.push) begin
            nxt = cur - int'(st.cnt);
            if (nxt < 0) begin
                us = 1'b1;
                nxt += span;
            end
        end else if (st.pull) begin
            nxt = cur + int'(st.cnt);
            if (nxt >= span) begin
                os = 1'b1;
                nxt -= span;
            end
        end
        n.s   = 16'(nxt);
        n.unf = us | (m.unf & ~st.clr);
        n.ovf = os | (m.ovf & ~st.clr);
        return n;
    endfunction

    function automatic stim_t mk(logic we, logic [2:0] ds, logic [15:0] d, logic [2:0] ss,
                                 logic [2:0] is, logic t, logic pu, logic pl,
                                 logic [1:0] c, logic cl);
        stim_t st;
        st.we = we; st.dst_sel = ds; st.dst = d; st.src_sel = ss; st.idx_sel = is;
        st.txs = t; st.push = pu; st.pull = pl; st.cnt = c; st.clr = cl;
        return st;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic driveIdle();
        reg_we = 0; reg_dst = 0; dst = 0; reg_src = 0; reg_idx = 0;
        txs = 0; push = 0; pull = 0; sp_cnt = 0; sp_clr = 0;
    endtask

    task automatic resetModels();
        mod_a = '0;
        mod_b = '0;
        mod_a.s = 16'hFF;
        mod_b.s = 16'h1FF;
    endtask

    task automatic applyStimulus(input stim_t st);
        exp_t   e;
        model_t na, nb;
        @(negedge clk);
        reg_we = st.we; reg_dst = st.dst_sel; dst = st.dst;
        reg_src = st.src_sel; reg_idx = st.idx_sel;
        txs = st.txs; push = st.push; pull = st.pull; sp_cnt = st.cnt; sp_clr = st.clr;
        na = model_step(mod_a, st, 1'b0, 4, 8, 8);
        nb = model_step(mod_b, st, 1'b1, 8, 16, 9);
        e.a_src_pre = model_read(mod_a, int'(st.src_sel) % 4, st, 1'b0, 4, 8);
        e.a_idx_pre = model_read(mod_a, int'(st.idx_sel) % 4, st, 1'b0, 4, 8);
        e.b_src_pre = model_read(mod_b, int'(st.src_sel), st, 1'b1, 8, 16);
        e.b_idx_pre = model_read(mod_b, int'(st.idx_sel), st, 1'b1, 8, 16);
        e.a_src = model_read(na, int'(st.src_sel) % 4, st, 1'b0, 4, 8);
        e.a_idx = model_read(na, int'(st.idx_sel) % 4, st, 1'b0, 4, 8);
        e.b_src = model_read(nb, int'(st.src_sel), st, 1'b1, 8, 16);
        e.b_idx = model_read(nb, int'(st.idx_sel), st, 1'b1, 8, 16);
        e.a_s = na.s; e.b_s = nb.s;
        e.a_unf = na.unf; e.a_ovf = na.ovf; e.b_unf = nb.unf; e.b_ovf = nb.ovf;
        sb.push_back(e);
        mod_a = na;
        mod_b = nb;
    endtask

    // Pre-edge reads are sampled mid-low-phase, post-edge state just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("a_src_pre", {8'h0, src_a}, e.a_src_pre);
                checkOutput("a_idx_pre", {8'h0, idx_a}, e.a_idx_pre);
                checkOutput("b_src_pre", src_b, e.b_src_pre);
                checkOutput("b_idx_pre", idx_b, e.b_idx_pre);
                @(posedge clk);
                #1;
                checkOutput("a_src", {8'h0, src_a}, e.a_src);
                checkOutput("a_idx", {8'h0, idx_a}, e.a_idx);
                checkOutput("a_S", {8'h0, s_a}, e.a_s);
                checkOutput("a_unf", {15'h0, unf_a}, {15'h0, e.a_unf});
                checkOutput("a_ovf", {15'h0, ovf_a}, {15'h0, e.a_ovf});
                checkOutput("b_src", src_b, e.b_src);
                checkOutput("b_idx", idx_b, e.b_idx);
                checkOutput("b_S", {7'h0, s_b}, e.b_s);
                checkOutput("b_unf", {15'h0, unf_b}, {15'h0, e.b_unf});
                checkOutput("b_ovf", {15'h0, ovf_b}, {15'h0, e.b_ovf});
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_a_S", {8'h0, s_a}, 16'h00FF);
        checkOutput("rst_b_S", {7'h0, s_b}, 16'h01FF);
        checkOutput("rst_flags", {12'h0, unf_a, ovf_a, unf_b, ovf_b}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            reg_src = 3'(i);
            reg_idx = 3'(7 - i);
            #1;
            checkOutput("rst_a_reg", {src_a, idx_a}, 16'h0);
            checkOutput("rst_b_src", src_b, 16'h0);
            checkOutput("rst_b_idx", idx_b, 16'h0);
        end
        reg_src = 0;
        reg_idx = 0;
    endtask

    initial begin
        driveIdle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        resetModels();
        checkResetState();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(mk(1, 3, 16'h0041, 3, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 1, 16'h0007, 3, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 3, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 2, 16'h005A, 2, 2, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 2, 3, 0, 1, 0, 2, 0));
        applyStimulus(mk(0, 0, 16'h0000, 2, 3, 0, 0, 1, 3, 0));
        applyStimulus(mk(0, 0, 16'h0000, 2, 3, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 2, 0));
        applyStimulus(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 1));
        applyStimulus(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, 1, 16'h0080, 1, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 1, 1, 1, 1, 1, 1, 0));
        applyStimulus(mk(1, 2, 16'h0040, 2, 2, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 2, 2, 1, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 2, 2, 0, 1, 1, 1, 0));
        applyStimulus(mk(0, 0, 16'h0000, 2, 2, 0, 1, 0, 0, 0));
        applyStimulus(mk(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));

        // Asynchronous reset mid-run with S=10: state must return without a clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        resetModels();
        driveIdle();
        checkResetState();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(mk(0, 0, 16'h0000, 7, 7, 0, 1, 0, 3, 0));
        applyStimulus(mk(1, 7, 16'hFFFF, 7, 7, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 16'h0000, 7, 7, 0, 0, 0, 0, 0));

        for (int n = 0; n < 400; n++) begin
            applyStimulus(mk(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                             3'($urandom), 3'($urandom), $urandom_range(0, 7) == 0,
                             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                             2'($urandom), $urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
